// File: rtl/param_inst_decoder.sv
// Instruction decoder: collects an opcode word plus its argument words over a valid/ready
// fetch port, issues one decoded bundle, and keeps a one-deep shadow of a partial instruction.
module param_inst_decoder #(
  parameter int DATA_W   = 16,
  parameter int OPC_W    = 8,
  parameter int MAX_ARGS = 3
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       i_lock,
  input  logic                       i_fetch_valid,
  input  logic [DATA_W-1:0]          i_fetch_data,
  output logic                       o_fetch_ready,
  output logic                       o_dec_valid,
  input  logic                       i_dec_ready,
  output logic [OPC_W-1:0]           o_dec_opcode,
  output logic [1:0]                 o_dec_nargs,
  output logic                       o_dec_io,
  output logic                       o_dec_illegal,
  output logic [MAX_ARGS*DATA_W-1:0] o_dec_args,
  input  logic                       i_interrupt,
  output logic                       o_int_ack,
  input  logic                       i_int_return,
  output logic                       o_nest_err
);

  typedef enum logic [1:0] {
    S_OPC   = 2'd0,
    S_ARGS  = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  localparam logic [2:0] MaxN = 3'(MAX_ARGS);

  state_e                          state_q, state_d;
  logic [OPC_W-1:0]                opcode_q, opcode_d;
  logic [1:0]                      nargs_q, nargs_d;
  logic [1:0]                      idx_q, idx_d;
  logic                            io_q, io_d;
  logic                            illegal_q, illegal_d;
  logic [MAX_ARGS-1:0][DATA_W-1:0] args_q, args_d;

  // The shadow only ever holds an instruction interrupted in ARGS, so no state field is kept.
  logic                            shadow_full_q, shadow_full_d;
  logic [OPC_W-1:0]                sh_opcode_q, sh_opcode_d;
  logic [1:0]                      sh_nargs_q, sh_nargs_d;
  logic [1:0]                      sh_idx_q, sh_idx_d;
  logic                            sh_io_q, sh_io_d;
  logic [MAX_ARGS-1:0][DATA_W-1:0] sh_args_q, sh_args_d;

  logic                            nest_err_q, nest_err_d;
  logic                            int_ack_q, int_ack_d;

  logic                            take_int;
  logic                            restore;
  logic                            accept;
  logic [1:0]                      word_n;
  logic                            word_illegal;

  assign take_int     = i_interrupt && !i_lock && (state_q != S_ISSUE);
  assign restore      = i_int_return && !i_interrupt && !i_lock && shadow_full_q && (state_q == S_OPC);
  assign accept       = o_fetch_ready && i_fetch_valid;
  assign word_n       = i_fetch_data[OPC_W+1:OPC_W];
  assign word_illegal = {1'b0, word_n} > MaxN;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= S_OPC;
      opcode_q      <= '0;
      nargs_q       <= '0;
      idx_q         <= '0;
      io_q          <= 1'b0;
      illegal_q     <= 1'b0;
      args_q        <= '0;
      shadow_full_q <= 1'b0;
      sh_opcode_q   <= '0;
      sh_nargs_q    <= '0;
      sh_idx_q      <= '0;
      sh_io_q       <= 1'b0;
      sh_args_q     <= '0;
      nest_err_q    <= 1'b0;
      int_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      nargs_q       <= nargs_d;
      idx_q         <= idx_d;
      io_q          <= io_d;
      illegal_q     <= illegal_d;
      args_q        <= args_d;
      shadow_full_q <= shadow_full_d;
      sh_opcode_q   <= sh_opcode_d;
      sh_nargs_q    <= sh_nargs_d;
      sh_idx_q      <= sh_idx_d;
      sh_io_q       <= sh_io_d;
      sh_args_q     <= sh_args_d;
      nest_err_q    <= nest_err_d;
      int_ack_q     <= int_ack_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    nargs_d       = nargs_q;
    idx_d         = idx_q;
    io_d          = io_q;
    illegal_d     = illegal_q;
    args_d        = args_q;
    shadow_full_d = shadow_full_q;
    sh_opcode_d   = sh_opcode_q;
    sh_nargs_d    = sh_nargs_q;
    sh_idx_d      = sh_idx_q;
    sh_io_d       = sh_io_q;
    sh_args_d     = sh_args_q;
    nest_err_d    = nest_err_q;
    // A lock freezes the ack too, so a pending pulse is simply stretched over the stall.
    int_ack_d     = i_lock ? int_ack_q : take_int;

    if (!i_lock) begin
      if (take_int) begin
        if (state_q == S_ARGS) begin
          if (shadow_full_q) begin
            nest_err_d = 1'b1;
          end else begin
            shadow_full_d = 1'b1;
            sh_opcode_d   = opcode_q;
            sh_nargs_d    = nargs_q;
            sh_idx_d      = idx_q;
            sh_io_d       = io_q;
            sh_args_d     = args_q;
          end
        end
        state_d = S_OPC;
      end else if (restore) begin
        shadow_full_d = 1'b0;
        opcode_d      = sh_opcode_q;
        nargs_d       = sh_nargs_q;
        idx_d         = sh_idx_q;
        io_d          = sh_io_q;
        args_d        = sh_args_q;
        illegal_d     = 1'b0;
        state_d       = S_ARGS;
      end else begin
        unique case (state_q)
          S_OPC: begin
            if (accept) begin
              opcode_d  = i_fetch_data[OPC_W-1:0];
              nargs_d   = word_n;
              io_d      = i_fetch_data[OPC_W+2];
              illegal_d = word_illegal;
              args_d    = '0;
              idx_d     = '0;
              state_d   = ((word_n == 2'd0) || word_illegal) ? S_ISSUE : S_ARGS;
            end
          end
          S_ARGS: begin
            if (accept) begin
              for (int k = 0; k < MAX_ARGS; k++) begin
                if (idx_q == 2'(k)) args_d[k] = i_fetch_data;
              end
              if (idx_q == nargs_q - 2'd1) state_d = S_ISSUE;
              else                         idx_d   = idx_q + 2'd1;
            end
          end
          S_ISSUE: begin
            if (i_dec_ready) state_d = S_OPC;
          end
          default: state_d = S_OPC;
        endcase
      end
    end
  end

  // The ready term is masked by reset and by a context restore so no word is ever dropped.
  always_comb begin
    o_fetch_ready = n_rst && (state_q != S_ISSUE) && !i_lock && !i_interrupt && !restore;
    o_dec_valid   = (state_q == S_ISSUE);
    o_dec_opcode  = opcode_q;
    o_dec_nargs   = nargs_q;
    o_dec_io      = io_q;
    o_dec_illegal = illegal_q;
    o_dec_args    = args_q;
    o_int_ack     = int_ack_q;
    o_nest_err    = nest_err_q;
  end

endmodule
